// File: rtl/sram_bus_ctrl.sv
// rtl/sram_bus_ctrl.sv - request/response front end timing strobes for an async SRAM
// Optional read/write transaction counters when SRAM_BUS_CTRL_PERF_EN is defined.

module sram_bus_ctrl #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 15,
    parameter int RD_WAIT = 6,
    parameter int WR_WAIT = 5
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic [A_WIDTH-1:0] mem_a,
    inout  wire  [D_WIDTH-1:0] mem_d,
    output logic               mem_n_oe,
    output logic               mem_n_we,
    output logic               mem_n_cs
`ifdef SRAM_BUS_CTRL_PERF_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t             state;
    logic [CW-1:0]      wait_cnt;
    logic [D_WIDTH-1:0] wdata_q;
    logic               drive_d;

    assign req_ready = (state == IDLE);

    // The only combinational path to a RAM pin: bus drive follows the write states.
    assign drive_d = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
    assign mem_d   = drive_d ? wdata_q : {D_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wdata_q   <= '0;
            mem_a     <= '0;
            mem_n_cs  <= 1'b1;
            mem_n_oe  <= 1'b1;
            mem_n_we  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SRAM_BUS_CTRL_PERF_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_a    <= req_addr;
                        mem_n_cs <= 1'b0;
                        if (req_we) begin
                            wdata_q <= req_wdata;
                            state   <= WR_SETUP;
                        end else begin
                            mem_n_oe <= 1'b0;
                            wait_cnt <= CW'(RD_WAIT - 1);
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == '0) begin
                        rsp_rdata <= mem_d;
                        rsp_valid <= 1'b1;
                        mem_n_cs  <= 1'b1;
                        mem_n_oe  <= 1'b1;
                        state     <= IDLE;
`ifdef SRAM_BUS_CTRL_PERF_EN
                        rd_count  <= rd_count + 16'd1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                WR_SETUP: begin
                    mem_n_we <= 1'b0;
                    wait_cnt <= CW'(WR_WAIT - 1);
                    state    <= WR_PULSE;
                end
                WR_PULSE: begin
                    // n_we rises while cs, address and data are still held for WR_HOLD.
                    if (wait_cnt == '0) begin
                        mem_n_we <= 1'b1;
                        state    <= WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                WR_HOLD: begin
                    mem_n_cs  <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
`ifdef SRAM_BUS_CTRL_PERF_EN
                    wr_count  <= wr_count + 16'd1;
`endif
                end
                default: begin
                    mem_n_cs <= 1'b1;
                    mem_n_oe <= 1'b1;
                    mem_n_we <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb/tb_sram_bus_ctrl.sv - self-checking bench for sram_bus_ctrl with an SRAM device model

module tb_sram_bus_ctrl;

    localparam int RD_WAIT = 6;
    localparam int WR_WAIT = 5;

    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [14:0] mem_a;
    wire  [7:0]  mem_d;
    logic        mem_n_oe;
    logic        mem_n_we;
    logic        mem_n_cs;
`ifdef SRAM_BUS_CTRL_PERF_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    sram_bus_ctrl #(
        .D_WIDTH(8),
        .A_WIDTH(15),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_n_oe  (mem_n_oe),
        .mem_n_we  (mem_n_we),
        .mem_n_cs  (mem_n_cs)
`ifdef SRAM_BUS_CTRL_PERF_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM device: drives the bus on cs&oe, latches on rising n_we.
    logic [7:0] ram [0:32767];
    assign mem_d = (!mem_n_cs && !mem_n_oe) ? ram[mem_a] : 8'bz;

    function automatic logic [7:0] init_val(input logic [14:0] a);
        return ~a[7:0];
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = init_val(15'(i));
        forever begin
            @(posedge mem_n_we);
            if (!mem_n_cs) ram[mem_a] = mem_d;
        end
    end

    // Strobe activity totals and bus-protocol violations, sampled mid-cycle.
    int          oe_cnt = 0;
    int          we_cnt = 0;
    int          cs_cnt = 0;
    int          viol   = 0;
    logic [14:0] cur_addr = '0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (!mem_n_oe) oe_cnt++;
            if (!mem_n_we) we_cnt++;
            if (!mem_n_cs) cs_cnt++;
            if (!mem_n_oe && !mem_n_we) viol++;
            if (!mem_n_we && mem_n_cs) viol++;
            if (!mem_n_cs && mem_a != cur_addr) viol++;
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Issues one request (inputs scrambled and req_valid held while busy) and waits for rsp_valid.
    task automatic do_op(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd,
                         output int n_oe, output int n_we, output int n_cs);
        int oe0, we0, cs0;
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        cur_addr  = addr;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        oe0 = oe_cnt; we0 = we_cnt; cs0 = cs_cnt;
        check("busy_after_accept", {31'd0, req_ready}, 32'd0);
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wd;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        rd   = rsp_rdata;
        n_oe = oe_cnt - oe0;
        n_we = we_cnt - we0;
        n_cs = cs_cnt - cs0;
    endtask

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wdata;
        int          gap;
        logic [7:0]  exp_rdata;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        int          exp_cs;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] model [int];

    initial begin
        int          lat, n_oe, n_we, n_cs, seen;
        logic [7:0]  rd;
        int          nrd, nwr;

        vecs[0] = '{1'b1, 15'h1234, 8'hA5, 1, 8'h00, 8, 0, 5, 7};
        vecs[1] = '{1'b0, 15'h1234, 8'h00, 2, 8'hA5, 7, 6, 0, 6};
        vecs[2] = '{1'b1, 15'h7FFF, 8'h3C, 0, 8'h00, 8, 0, 5, 7};
        vecs[3] = '{1'b0, 15'h7FFF, 8'h00, 0, 8'h3C, 7, 6, 0, 6};
        vecs[4] = '{1'b1, 15'h0000, 8'hFF, 1, 8'h00, 8, 0, 5, 7};
        vecs[5] = '{1'b0, 15'h0000, 8'h00, 0, 8'hFF, 7, 6, 0, 6};
        vecs[6] = '{1'b0, 15'h0001, 8'h00, 3, 8'hFE, 7, 6, 0, 6};
        vecs[7] = '{1'b0, 15'h1234, 8'h00, 0, 8'hA5, 7, 6, 0, 6};

        n_rst     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 15'h5555;
        req_wdata = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_strobes", {29'd0, mem_n_cs, mem_n_oe, mem_n_we}, 32'd7);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_mem_a", {17'd0, mem_a}, 32'd0);
        req_valid = 1'b0;
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        nrd = 0; nwr = 0;
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].gap) begin
                @(posedge clk);
                #1;
            end
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, n_oe, n_we, n_cs);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_oe_cycles", i), n_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_we_cycles", i), n_we, vecs[i].exp_we);
            check($sformatf("vec%0d_cs_cycles", i), n_cs, vecs[i].exp_cs);
            if (vecs[i].we) begin
                model[int'(vecs[i].addr)] = vecs[i].wdata;
                nwr++;
            end else begin
                check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rdata});
                nrd++;
            end
        end
        check("ram_0x1234", {24'd0, ram[15'h1234]}, 32'hA5);
        check("ram_0x7fff", {24'd0, ram[15'h7FFF]}, 32'h3C);
`ifdef SRAM_BUS_CTRL_PERF_EN
        check("perf_wr_count", {16'd0, wr_count}, nwr);
        check("perf_rd_count", {16'd0, rd_count}, nrd);
`endif

        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [14:0] addr;
            logic [7:0]  wd, exp;
            we   = 1'($urandom_range(0, 1));
            addr = 15'($urandom_range(0, 15) * 32'h811);
            wd   = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            do_op(we, addr, wd, lat, rd, n_oe, n_we, n_cs);
            check($sformatf("rand%0d_lat", i), lat, we ? WR_WAIT + 3 : RD_WAIT + 1);
            if (we) begin
                model[int'(addr)] = wd;
            end else begin
                exp = model.exists(int'(addr)) ? model[int'(addr)] : init_val(addr);
                check($sformatf("rand%0d_rdata", i), {24'd0, rd}, {24'd0, exp});
            end
        end

        // Reset asserted in the third RD cycle must abort without a response.
        @(posedge clk);
        #1;
        cur_addr  = 15'h1234;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrd_oe_low", {31'd0, mem_n_oe}, 32'd0);
        n_rst = 1'b0;
        #1;
        check("midrd_strobes", {29'd0, mem_n_cs, mem_n_oe, mem_n_we}, 32'd7);
        check("midrd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrd_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(posedge clk);
        #3;
        n_rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("midrd_no_rsp", seen, 0);
        check("midrd_ready", {31'd0, req_ready}, 32'd1);
        check("midrd_rdata_cleared", {24'd0, rsp_rdata}, 32'd0);

        do_op(1'b0, 15'h7FFF, 8'h00, lat, rd, n_oe, n_we, n_cs);
        check("post_rst_read_lat", lat, RD_WAIT + 1);
        check("post_rst_read_data", {24'd0, rd}, {24'd0, model[int'(15'h7FFF)]});

        check("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
